// File: rtl/posit_defines.sv
// rtl/posit_defines.sv - posit widths and decoded operand/product types
package posit_defines;

   localparam int NBITS = 32;
   localparam int ES    = 2;
   localparam int FBITS = NBITS - ES - 3;

   // Decoded operand from the extraction stage; hidden bit is implied.
   typedef struct packed {
      logic                    sign;
      logic                    zero;
      logic                    inf;
      logic signed [7:0]       scale;
      logic [FBITS-1:0]        fraction;
   } value;

   // Unrounded normalized product; shared with the round/encode stage.
   typedef struct packed {
      logic                    sign;
      logic                    zero;
      logic                    inf;
      logic signed [8:0]       scale;
      logic [2*FBITS:0]        fraction;
   } value_product;

endpackage

// File: rtl/posit_mant_mul.sv
// rtl/posit_mant_mul.sv - combinational unsigned mantissa multiplier
module posit_mant_mul #(
   parameter int W = 28
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);

   // Operands are zero-extended so the product is computed at full width.
   assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/posit_mul_pipe.sv
// rtl/posit_mul_pipe.sv - three-stage elastic posit multiplier
module posit_mul_pipe
   import posit_defines::*;
#(
   parameter int NBITS    = posit_defines::NBITS,
   parameter int ES       = posit_defines::ES,
   parameter int TAG_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  value                in_a,
   input  value                in_b,
   input  logic [TAG_BITS-1:0] in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output value_product        out,
   output logic [TAG_BITS-1:0] out_tag,
   output logic                busy
);

   localparam int FB = NBITS - ES - 3;
   localparam int MW = FB + 1;
   localparam int PW = 2 * MW;

   typedef struct packed {
      logic                sign;
      logic                zero;
      logic                inf;
      logic signed [8:0]   scale;
      logic [MW-1:0]       ma;
      logic [MW-1:0]       mb;
      logic [TAG_BITS-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic                sign;
      logic                zero;
      logic                inf;
      logic signed [8:0]   scale;
      logic [PW-1:0]       prod;
      logic [TAG_BITS-1:0] tag;
   } s2_t;

   logic                v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
   logic                adv1, adv2, adv3;
   s1_t                 s1_q, s1_d;
   s2_t                 s2_q, s2_d;
   value_product        out_q, out_d, norm;
   logic [TAG_BITS-1:0] tag3_q, tag3_d;
   logic [PW-1:0]       prod;

   posit_mant_mul #(.W(MW)) u_mul (
      .a_i (s1_q.ma),
      .b_i (s1_q.mb),
      .p_o (prod)
   );

   // Advance chain ripples back from the consumer; an empty stage always advances.
   always_comb begin
      adv3     = out_ready | ~v3_q;
      adv2     = adv3 | ~v2_q;
      adv1     = adv2 | ~v1_q;
      in_ready = adv1;
      v1_d     = adv1 ? in_valid : v1_q;
      v2_d     = adv2 ? v1_q : v2_q;
      v3_d     = adv3 ? v2_q : v3_q;
   end

   // S1: combine flags and scales, attach hidden bits to the mantissas.
   always_comb begin
      s1_d = s1_q;
      if (adv1) begin
         s1_d.sign  = in_a.sign ^ in_b.sign;
         s1_d.inf   = in_a.inf | in_b.inf;
         s1_d.zero  = (in_a.zero | in_b.zero) & ~(in_a.inf | in_b.inf);
         s1_d.scale = {in_a.scale[7], in_a.scale} + {in_b.scale[7], in_b.scale};
         s1_d.ma    = {1'b1, in_a.fraction};
         s1_d.mb    = {1'b1, in_b.fraction};
         s1_d.tag   = in_tag;
      end
   end

   // S2: register the full-width mantissa product with the carried fields.
   always_comb begin
      s2_d = s2_q;
      if (adv2) begin
         s2_d.sign  = s1_q.sign;
         s2_d.zero  = s1_q.zero;
         s2_d.inf   = s1_q.inf;
         s2_d.scale = s1_q.scale;
         s2_d.prod  = prod;
         s2_d.tag   = s1_q.tag;
      end
   end

   // S3: one-bit normalize, strip the hidden bit, then force NaR/zero encodings.
   always_comb begin
      norm      = '0;
      norm.sign = s2_q.sign;
      norm.zero = s2_q.zero;
      norm.inf  = s2_q.inf;
      if (s2_q.prod[PW-1]) begin
         norm.scale    = s2_q.scale + 9'sd1;
         norm.fraction = s2_q.prod[PW-2:0];
      end else begin
         norm.scale    = s2_q.scale;
         norm.fraction = {s2_q.prod[PW-3:0], 1'b0};
      end
      if (s2_q.inf) begin
         norm.sign     = 1'b1;
         norm.scale    = '0;
         norm.fraction = '0;
      end else if (s2_q.zero) begin
         norm.sign     = 1'b0;
         norm.scale    = '0;
         norm.fraction = '0;
      end
      out_d  = adv3 ? norm : out_q;
      tag3_d = adv3 ? s2_q.tag : tag3_q;
   end

   // Stage registers; reset empties the pipeline and clears the output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
         out_q  <= '0;
         tag3_q <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         out_q  <= out_d;
         tag3_q <= tag3_d;
      end
   end

   assign out_valid = v3_q;
   assign out       = out_q;
   assign out_tag   = tag3_q;
   assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_posit_mul_pipe.sv
// tb/tb_posit_mul_pipe.sv - self-checking bench for posit_mul_pipe
module tb_posit_mul_pipe;
   import posit_defines::*;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   value         in_a, in_b;
   logic [7:0]   in_tag;
   logic         out_valid;
   logic         out_ready;
   value_product out;
   logic [7:0]   out_tag;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int out_cnt = 0;

   typedef struct {
      value_product p;
      logic [7:0]   tag;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      string        name;
      value         a;
      value         b;
      logic [7:0]   tag;
      value_product exp;
   } vec_t;
   vec_t vecs[7];

   logic         prev_stall = 1'b0;
   value_product prev_out;
   logic [7:0]   prev_tag;

   posit_mul_pipe #(.TAG_BITS(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic value mk(logic s, logic z, logic i, int sc, logic [FBITS-1:0] f);
      value v;
      v.sign = s; v.zero = z; v.inf = i; v.scale = 8'(sc); v.fraction = f;
      return v;
   endfunction

   function automatic value_product mkp(logic s, logic z, logic i, int sc, logic [2*FBITS:0] f);
      value_product v;
      v.sign = s; v.zero = z; v.inf = i; v.scale = 9'(sc); v.fraction = f;
      return v;
   endfunction

   // Reference: exact mantissa product, then locate the leading one and left-align the rest.
   function automatic value_product ref_mul(value a, value b);
      value_product r;
      longint unsigned ma, mb, p, sh;
      int msb, sc;
      r = '0;
      if (a.inf || b.inf) begin
         r.inf = 1'b1; r.sign = 1'b1;
         return r;
      end
      if (a.zero || b.zero) begin
         r.zero = 1'b1;
         return r;
      end
      ma = (64'd1 << FBITS) + 64'(a.fraction);
      mb = (64'd1 << FBITS) + 64'(b.fraction);
      p = ma * mb;
      msb = 0;
      for (int i = 0; i < 64; i++) if (p[i]) msb = i;
      sc = int'($signed(a.scale)) + int'($signed(b.scale)) + (msb - 2 * FBITS);
      sh = p << (2 * FBITS + 1 - msb);
      r.sign = a.sign ^ b.sign;
      r.scale = 9'(sc);
      r.fraction = sh[2*FBITS:0];
      return r;
   endfunction

   function automatic value rand_val();
      value v;
      v.sign = 1'($urandom);
      v.zero = ($urandom_range(0, 15) == 0);
      v.inf = ($urandom_range(0, 15) == 0);
      v.scale = 8'($urandom);
      v.fraction = FBITS'($urandom);
      return v;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push the reference on every input transfer, pop on every output transfer.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || out !== prev_out || out_tag !== prev_tag) begin
               errors++;
               $display("FAIL stall_hold: got v=%b %h/%h expected %h/%h", out_valid, out, out_tag, prev_out, prev_tag);
            end
         end
         if (out_valid && out_ready) begin
            exp_t e;
            out_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got tag %h with no pending entry", out_tag);
            end else begin
               e = exp_q.pop_front();
               if (out !== e.p || out_tag !== e.tag) begin
                  errors++;
                  $display("FAIL sb_data: got %h tag %h expected %h tag %h", out, out_tag, e.p, e.tag);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_t n;
            n.p = ref_mul(in_a, in_b);
            n.tag = in_tag;
            exp_q.push_back(n);
         end
         prev_stall = out_valid && !out_ready;
         prev_out = out;
         prev_tag = out_tag;
      end
   end

   task automatic drain(string name);
      int n;
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, {120'd0, busy, 7'(exp_q.size())}, 128'd0);
   endtask

   initial begin
      int lat, acc, first_block, cnt0, next_tag, n, seen;
      reset_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_tag = '0;
      out_ready = 1'b0;

      vecs[0] = '{"mul_1p5", mk(0,0,0,0,27'h4000000), mk(0,0,0,0,27'h4000000), 8'h11,
                  mkp(0,0,0,1,55'h1 << 52)};
      vecs[1] = '{"sign_scale", mk(1,0,0,-3,27'h0), mk(0,0,0,5,27'h0), 8'h22,
                  mkp(1,0,0,2,55'h0)};
      vecs[2] = '{"zero_x_inf", mk(0,1,0,4,27'h123), mk(0,0,1,9,27'h0), 8'h33,
                  mkp(1,0,1,0,55'h0)};
      vecs[3] = '{"zero_x_one", mk(1,1,0,0,27'h0), mk(0,0,0,0,27'h0), 8'h44,
                  mkp(0,1,0,0,55'h0)};
      vecs[4] = '{"scale_max", mk(0,0,0,127,27'h7FFFFFF), mk(1,0,0,127,27'h7FFFFFF), 8'h55,
                  mkp(1,0,0,255,55'h7F_FFFF_E000_0001)};
      vecs[5] = '{"scale_min", mk(1,0,0,-128,27'h0), mk(1,0,0,-128,27'h0), 8'h66,
                  mkp(0,0,0,-256,55'h0)};
      vecs[6] = '{"inf_x_inf", mk(0,0,1,3,27'h5), mk(0,0,1,-7,27'h9), 8'h77,
                  mkp(1,0,1,0,55'h0)};

      #12;
      chk("reset_outputs", {59'd0, out_valid, busy, out, out_tag}, 128'd0);
      #5;
      reset_n = 1'b1;
      #1;
      chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
      tick();

      // Directed vectors, one at a time with the consumer always ready.
      for (int i = 0; i < 7; i++) begin
         out_ready = 1'b1;
         in_valid = 1'b1;
         in_a = vecs[i].a;
         in_b = vecs[i].b;
         in_tag = vecs[i].tag;
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 10) begin
            tick();
            lat++;
         end
         chk({vecs[i].name, "_latency"}, 128'(lat), 128'd3);
         chk({vecs[i].name, "_out"}, {61'd0, out}, {61'd0, vecs[i].exp});
         chk({vecs[i].name, "_tag"}, {120'd0, out_tag}, {120'd0, vecs[i].tag});
         tick();
      end
      drain("directed");

      // Randomized traffic with random back-pressure against the reference model.
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_a = rand_val();
         in_b = rand_val();
         in_tag = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain("random");

      // Back-pressure: ten tagged pairs, consumer stalled for cycles 2..8.
      cnt0 = out_cnt;
      next_tag = 0;
      acc = 0;
      first_block = -1;
      n = 0;
      while ((next_tag < 10 || busy) && n < 300) begin
         if (n < 2) out_ready = 1'b1;
         else if (n <= 8) out_ready = 1'b0;
         else out_ready = 1'($urandom);
         in_valid = (next_tag < 10);
         in_a = rand_val();
         in_b = rand_val();
         in_tag = 8'(next_tag);
         #1;
         if (in_valid && !in_ready && first_block < 0) first_block = acc;
         if (in_valid && in_ready) begin
            next_tag++;
            acc++;
         end
         tick();
         n++;
      end
      chk("bp_accepted_before_block", 128'(first_block), 128'd3);
      chk("bp_output_count", 128'(out_cnt - cnt0), 128'd10);
      drain("backpressure");

      // Reset with three entries in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_a = rand_val();
         in_b = rand_val();
         in_tag = 8'(8'hA0 + k);
         tick();
      end
      in_valid = 1'b0;
      chk("full_state", {125'd0, out_valid, busy, in_ready}, {125'd0, 3'b110});
      out_ready = 1'b1;
      #1;
      chk("in_ready_follows_out_ready", {127'd0, in_ready}, 128'd1);
      out_ready = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", {59'd0, out_valid, busy, out, out_tag}, 128'd0);
      cnt0 = out_cnt;
      tick();
      tick();
      #2;
      reset_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("post_reset_no_output", 128'(seen), 128'd0);
      chk("post_reset_no_transfer", 128'(out_cnt - cnt0), 128'd0);
      chk("post_reset_in_ready", {127'd0, in_ready}, 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
